// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : step_sequencer
// Purpose  : NUM_CH x NUM_STEPS pattern sequencer with tempo-aligned start,
//            programmable bar length, per-channel mute and bar-wrap strobe.
// Revision : 1.0 - initial release
// ============================================================================
module step_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = 3,
    parameter int CH_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_tick,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [NUM_STEPS-1:0] wr_pattern,
    input  logic [STEP_W:0]      length,
    input  logic [NUM_CH-1:0]    mute,
    output logic [NUM_CH-1:0]    trig,
    output logic [STEP_W-1:0]    step,
    output logic                 playing,
    output logic                 armed,
    output logic                 bar_wrap,
    output logic [NUM_STEPS-1:0] rd_pattern
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    localparam logic [STEP_W:0]   c_NUM_STEPS = (STEP_W+1)'(NUM_STEPS);
    localparam logic [STEP_W:0]   c_LEN_ONE   = (STEP_W+1)'(1);
    localparam logic [STEP_W-1:0] c_STEP_ONE  = STEP_W'(1);
    localparam logic [CH_W:0]     c_NUM_CH    = (CH_W+1)'(NUM_CH);

    state_t                r_state;
    logic [STEP_W-1:0]     r_step;
    logic [STEP_W:0]       r_len;
    logic [NUM_CH-1:0]     r_trig;
    logic                  r_bar_wrap;
    logic [NUM_STEPS-1:0]  r_rd;
    logic [NUM_STEPS-1:0]  r_rows [NUM_CH];

    state_t                w_state_nxt;
    logic [STEP_W-1:0]     w_step_nxt;
    logic [STEP_W:0]       w_len_nxt;
    logic [STEP_W:0]       w_len_eff;
    logic [NUM_CH-1:0]     w_trig_nxt;
    logic                  w_wrap_nxt;
    logic                  w_fire;
    logic                  w_ch_ok;

    // Out-of-range lengths fall back to a full-width bar.
    assign w_len_eff = (length == '0 || length > c_NUM_STEPS) ? c_NUM_STEPS : length;
    assign w_ch_ok   = ({1'b0, wr_ch} < c_NUM_CH);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_len_nxt   = r_len;
        w_trig_nxt  = '0;
        w_wrap_nxt  = 1'b0;
        w_fire      = 1'b0;
        if (stop && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) w_state_nxt = S_ARM;
                end
                S_ARM: begin
                    if (step_tick) begin
                        w_state_nxt = S_PLAY;
                        w_step_nxt  = '0;
                        w_len_nxt   = w_len_eff;
                        w_fire      = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (step_tick) begin
                        w_fire = 1'b1;
                        if ({1'b0, r_step} + c_LEN_ONE >= r_len) begin
                            w_step_nxt = '0;
                            w_wrap_nxt = 1'b1;
                            w_len_nxt  = w_len_eff;
                        end else begin
                            w_step_nxt = r_step + c_STEP_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                end
            endcase
        end
        // Rows are read before this edge's write lands, so a same-cycle write uses the old row.
        if (w_fire) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_trig_nxt[c] = r_rows[c][w_step_nxt] & ~mute[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_len      <= c_NUM_STEPS;
            r_trig     <= '0;
            r_bar_wrap <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_len      <= w_len_nxt;
            r_trig     <= w_trig_nxt;
            r_bar_wrap <= w_wrap_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_rows[c] <= '0;
            end
            r_rd <= '0;
        end else begin
            if (wr_en && w_ch_ok) r_rows[wr_ch] <= wr_pattern;
            r_rd <= w_ch_ok ? r_rows[wr_ch] : '0;
        end
    end

    assign trig       = r_trig;
    assign step       = r_step;
    assign playing    = (r_state == S_PLAY);
    assign armed      = (r_state == S_ARM);
    assign bar_wrap   = r_bar_wrap;
    assign rd_pattern = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_sequencer
// Purpose  : Directed scenarios plus random traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;
    localparam int NUM_CH    = 4;
    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = 3;
    localparam int CH_W      = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 step_tick = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 wr_en = 1'b0;
    logic [CH_W-1:0]      wr_ch = '0;
    logic [NUM_STEPS-1:0] wr_pattern = '0;
    logic [STEP_W:0]      length = '0;
    logic [NUM_CH-1:0]    mute = '0;
    logic [NUM_CH-1:0]    trig;
    logic [STEP_W-1:0]    step;
    logic                 playing;
    logic                 armed;
    logic                 bar_wrap;
    logic [NUM_STEPS-1:0] rd_pattern;

    step_sequencer #(
        .NUM_CH(NUM_CH), .NUM_STEPS(NUM_STEPS), .STEP_W(STEP_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .step_tick(step_tick), .start(start),
        .stop(stop), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pattern(wr_pattern),
        .length(length), .mute(mute), .trig(trig), .step(step),
        .playing(playing), .armed(armed), .bar_wrap(bar_wrap),
        .rd_pattern(rd_pattern)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference
    logic [NUM_STEPS-1:0] m_rows [NUM_CH];
    string                m_mode;
    int                   m_step;
    int                   m_len;
    logic [NUM_CH-1:0]    e_trig;
    logic                 e_wrap;
    logic [NUM_STEPS-1:0] e_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] hits(input int s);
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = m_rows[c][s] & ~mute[c];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) m_rows[c] = '0;
        m_mode = "IDLE";
        m_step = 0;
        m_len  = NUM_STEPS;
        e_trig = '0;
        e_wrap = 1'b0;
        e_rd   = '0;
    endtask

    task automatic model_edge();
        int eff;
        eff = int'(length);
        if (eff == 0 || eff > NUM_STEPS) eff = NUM_STEPS;
        e_trig = '0;
        e_wrap = 1'b0;
        e_rd   = (int'(wr_ch) < NUM_CH) ? m_rows[wr_ch] : '0;
        if (stop) begin
            if (m_mode != "IDLE") begin
                m_mode = "IDLE";
                m_step = 0;
            end
        end else if (m_mode == "IDLE") begin
            if (start) m_mode = "ARM";
        end else if (m_mode == "ARM") begin
            if (step_tick) begin
                m_mode = "PLAY";
                m_step = 0;
                m_len  = eff;
                e_trig = hits(0);
            end
        end else if (step_tick) begin
            m_step = (m_step + 1) % m_len;
            if (m_step == 0) begin
                e_wrap = 1'b1;
                m_len  = eff;
            end
            e_trig = hits(m_step);
        end
        if (wr_en && int'(wr_ch) < NUM_CH) m_rows[wr_ch] = wr_pattern;
    endtask

    task automatic check_all();
        check_eq("trig", 32'(trig), 32'(e_trig));
        check_eq("step", 32'(step), 32'(m_step));
        check_eq("playing", 32'(playing), 32'(m_mode == "PLAY"));
        check_eq("armed", 32'(armed), 32'(m_mode == "ARM"));
        check_eq("bar_wrap", 32'(bar_wrap), 32'(e_wrap));
        check_eq("rd_pattern", 32'(rd_pattern), 32'(e_rd));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; step_tick = 1'b0;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nwrap;
        int t2 [9] = '{0, 1, 2, 0, 1, 2, 3, 4, 0};
        model_reset();
        do_reset();

        // Scenario 1: sparse row 0, full bar
        wr_ch = 2'd0; wr_pattern = 8'h11; wr_en = 1'b1; cycle();
        start = 1'b1; cycle();
        check_eq("t1_armed", 32'(armed), 32'd1);
        nwrap = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq("t1_step", 32'(step), 32'(i % 8));
            check_eq("t1_trig0", 32'(trig[0]), 32'(i % 4 == 0));
            nwrap += int'(bar_wrap);
        end
        check_eq("t1_wraps", 32'(nwrap), 32'd1);

        // Scenario 2: short bar, length change mid-bar
        stop = 1'b1; cycle();
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ch = CH_W'(c); wr_pattern = 8'hFF; wr_en = 1'b1; cycle();
        end
        length = 4'd3; start = 1'b1; cycle();
        for (int i = 0; i < 9; i++) begin
            if (i == 2) length = 4'd5;
            tick();
            check_eq("t2_step", 32'(step), 32'(t2[i]));
            check_eq("t2_wrap", 32'(bar_wrap), 32'(i > 0 && t2[i] == 0));
            check_eq("t2_trig", 32'(trig), 32'hF);
        end

        // Scenario 3: mute
        mute = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_muted", 32'(trig), 32'b1101);
        end
        mute = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("t3_unmuted", 32'(trig), 32'hF);
        end

        // Scenario 4: stop beats start; tick coinciding with start is ignored
        start = 1'b1; stop = 1'b1; cycle();
        check_eq("t4_stopped", 32'(playing), 32'd0);
        check_eq("t4_step0", 32'(step), 32'd0);
        length = 4'd8; start = 1'b1; step_tick = 1'b1; cycle();
        check_eq("t4_armed", 32'(armed), 32'd1);
        check_eq("t4_notrig", 32'(trig), 32'd0);
        tick();
        check_eq("t4_play", 32'(playing), 32'd1);
        check_eq("t4_first", 32'(step), 32'd0);

        // Scenario 5: write colliding with a tick
        wr_ch = 2'd2; wr_pattern = 8'h08; wr_en = 1'b1; cycle();
        tick(); tick();
        wr_pattern = 8'h00; wr_en = 1'b1; tick();
        check_eq("t5_step3", 32'(step), 32'd3);
        check_eq("t5_oldrow", 32'(trig[2]), 32'd1);
        cycle();
        check_eq("t5_rd", 32'(rd_pattern), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check_eq("t5_newrow", 32'(trig[2]), 32'd0);

        // Scenario 6: reset mid-bar
        tick(); tick();
        check_eq("t6_step5", 32'(step), 32'd5);
        do_reset();
        check_eq("t6_rst_step", 32'(step), 32'd0);
        check_eq("t6_rst_play", 32'(playing), 32'd0);
        start = 1'b1; cycle();
        tick();
        check_eq("t6_play", 32'(playing), 32'd1);
        check_eq("t6_cleared", 32'(trig), 32'd0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step_tick  = ($urandom_range(0, 2) == 0);
            start      = ($urandom_range(0, 9) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            wr_en      = ($urandom_range(0, 5) == 0);
            wr_ch      = CH_W'($urandom_range(0, 3));
            wr_pattern = NUM_STEPS'($urandom);
            if ($urandom_range(0, 15) == 0) length = (STEP_W+1)'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mute = NUM_CH'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
